// File: rtl/poly_note_player.sv
// poly_note_player
//   Multi-voice note player. Each of NUM_VOICES voices holds a note and a
//   beat-counted duration and feeds its own frequency ROM and sine reader.
//   On a codec request, all sine readers are asked for their next sample.
//   The mixer waits for every voice, then sums the captured samples, scales
//   the sum down and saturates it into one registered output sample.
// Ports
//   clk                  system clock
//   reset                asynchronous, active-low reset
//   play_enable          1 = play, 0 = pause (counters freeze, voices silent)
//   load_new_note        load strobe for voice voice_sel
//   voice_sel            target voice; values >= NUM_VOICES are ignored
//   note_to_load         note for the loaded voice (0 = rest)
//   duration_to_load     duration for the loaded voice, in beats
//   beat                 1/48 s beat strobe
//   generate_next_sample codec request strobe
//   done_with_note       per voice, 1 while its remaining time is 0
//   all_done             AND of done_with_note
//   sample_out           mixed signed sample, held between pulses
//   new_sample_ready     one-cycle pulse when sample_out is updated
//   overrun              sticky flag: request arrived while mixer was busy

module pnp_frequency_rom #(
  parameter int NOTE_W = 6,
  parameter int STEP_W = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NOTE_W-1:0] note,
  output logic [STEP_W-1:0] step_size
);

  logic [NOTE_W-1:0] idx_c;
  logic [NOTE_W-1:0] oct_c;
  logic [3:0]        semi_c;
  logic [11:0]       base_c;

  // Note 1 is A1 (55 Hz); twelve semitones per octave, octaves by doubling.
  always_comb begin
    idx_c  = note - NOTE_W'(1);
    semi_c = 4'(idx_c % NOTE_W'(12));
    oct_c  = idx_c / NOTE_W'(12);
    case (semi_c)
      4'd0:    base_c = 12'd1201;
      4'd1:    base_c = 12'd1273;
      4'd2:    base_c = 12'd1348;
      4'd3:    base_c = 12'd1429;
      4'd4:    base_c = 12'd1514;
      4'd5:    base_c = 12'd1604;
      4'd6:    base_c = 12'd1699;
      4'd7:    base_c = 12'd1800;
      4'd8:    base_c = 12'd1907;
      4'd9:    base_c = 12'd2021;
      4'd10:   base_c = 12'd2141;
      4'd11:   base_c = 12'd2268;
      default: base_c = 12'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_size <= '0;
    end else if (note == '0) begin
      step_size <= '0;
    end else begin
      step_size <= STEP_W'(base_c) << oct_c;
    end
  end

endmodule

module pnp_sine_reader #(
  parameter int STEP_W   = 20,
  parameter int SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                generate_next,
  input  logic [STEP_W-1:0]   step_size,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_ready
);

  logic [STEP_W-1:0]     phase_reg;
  logic                  v1_reg;
  logic                  v2_reg;
  logic [15:0]           mag_reg;
  logic                  neg_reg;
  logic [3:0]            idx_c;
  logic [15:0]           signed_c;
  logic [SAMPLE_W+15:0]  wide_c;

  // Quarter-wave table sampled at half-step offsets so that mirroring the
  // index (~idx) gives the second quadrant without a duplicated peak.
  function automatic logic [15:0] quarter_sine(input logic [3:0] a);
    case (a)
      4'd0:    quarter_sine = 16'd1608;
      4'd1:    quarter_sine = 16'd4808;
      4'd2:    quarter_sine = 16'd7962;
      4'd3:    quarter_sine = 16'd11039;
      4'd4:    quarter_sine = 16'd14010;
      4'd5:    quarter_sine = 16'd16846;
      4'd6:    quarter_sine = 16'd19520;
      4'd7:    quarter_sine = 16'd22005;
      4'd8:    quarter_sine = 16'd24279;
      4'd9:    quarter_sine = 16'd26319;
      4'd10:   quarter_sine = 16'd28106;
      4'd11:   quarter_sine = 16'd29621;
      4'd12:   quarter_sine = 16'd30852;
      4'd13:   quarter_sine = 16'd31785;
      4'd14:   quarter_sine = 16'd32412;
      default: quarter_sine = 16'd32728;
    endcase
  endfunction

  always_comb begin
    idx_c    = phase_reg[STEP_W-3 -: 4];
    signed_c = neg_reg ? (16'd0 - mag_reg) : mag_reg;
    // Rescale the 16-bit table value to SAMPLE_W by keeping its top bits.
    wide_c   = {signed_c, SAMPLE_W'(0)};
  end

  // Three-stage pipeline: advance phase, table read, sign and output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_reg    <= '0;
      v1_reg       <= 1'b0;
      v2_reg       <= 1'b0;
      mag_reg      <= '0;
      neg_reg      <= 1'b0;
      sample       <= '0;
      sample_ready <= 1'b0;
    end else begin
      v1_reg       <= generate_next;
      v2_reg       <= v1_reg;
      sample_ready <= v2_reg;
      if (generate_next) begin
        phase_reg <= phase_reg + step_size;
      end
      if (v1_reg) begin
        mag_reg <= quarter_sine(phase_reg[STEP_W-2] ? ~idx_c : idx_c);
        neg_reg <= phase_reg[STEP_W-1];
      end
      if (v2_reg) begin
        sample <= wide_c[SAMPLE_W+15 -: SAMPLE_W];
      end
    end
  end

endmodule

module poly_note_player #(
  parameter int NUM_VOICES  = 4,
  parameter int NOTE_W      = 6,
  parameter int DUR_W       = 6,
  parameter int SAMPLE_W    = 16,
  parameter int GAIN_SHIFT  = $clog2(NUM_VOICES),
  localparam int VSEL_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  play_enable,
  input  logic                  load_new_note,
  input  logic [VSEL_W-1:0]     voice_sel,
  input  logic [NOTE_W-1:0]     note_to_load,
  input  logic [DUR_W-1:0]      duration_to_load,
  input  logic                  beat,
  input  logic                  generate_next_sample,
  output logic [NUM_VOICES-1:0] done_with_note,
  output logic                  all_done,
  output logic [SAMPLE_W-1:0]   sample_out,
  output logic                  new_sample_ready,
  output logic                  overrun
);

  localparam int SUM_W  = SAMPLE_W + $clog2(NUM_VOICES);
  localparam int STEP_W = 20;
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((2 ** (SAMPLE_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(2 ** (SAMPLE_W - 1)));

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SUM} mix_state_t;

  mix_state_t state_reg;
  mix_state_t state_next;
  logic       sine_gen;

  logic [NUM_VOICES-1:0]          voice_ready;
  logic [NUM_VOICES-1:0]          voice_active;
  logic [NUM_VOICES-1:0]          got_flat;
  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample_raw;
  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample;
  logic [NUM_VOICES*SAMPLE_W-1:0] cap_flat;

  logic signed [SUM_W-1:0]    sum_c;
  logic signed [SUM_W-1:0]    shifted_c;
  logic        [SAMPLE_W-1:0] sat_c;

  // All voice samples enter the mixer through this one vector.
  assign voice_sample = voice_sample_raw;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
      logic [NOTE_W-1:0]   note_reg;
      logic [DUR_W-1:0]    remain_reg;
      logic [STEP_W-1:0]   step_size;
      logic                got_reg;
      logic [SAMPLE_W-1:0] cap_reg;

      // A load wins over a same-cycle beat for this voice only.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          note_reg   <= '0;
          remain_reg <= '0;
        end else if (load_new_note && (voice_sel == VSEL_W'(gi))) begin
          note_reg   <= note_to_load;
          remain_reg <= duration_to_load;
        end else if (beat && play_enable && (remain_reg != '0)) begin
          remain_reg <= remain_reg - DUR_W'(1);
        end
      end

      assign done_with_note[gi] = (remain_reg == '0);
      assign voice_active[gi]   = (remain_reg != '0) && (note_reg != '0) && play_enable;

      pnp_frequency_rom #(
        .NOTE_W (NOTE_W),
        .STEP_W (STEP_W)
      ) u_rom (
        .clk       (clk),
        .reset     (reset),
        .note      (note_reg),
        .step_size (step_size)
      );

      pnp_sine_reader #(
        .STEP_W   (STEP_W),
        .SAMPLE_W (SAMPLE_W)
      ) u_sine (
        .clk           (clk),
        .reset         (reset),
        .generate_next (sine_gen),
        .step_size     (step_size),
        .sample        (voice_sample_raw[gi*SAMPLE_W +: SAMPLE_W]),
        .sample_ready  (voice_ready[gi])
      );

      // Activity is judged when the sample is captured, so a pause that
      // lands mid-request silences the voices that have not reported yet.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          got_reg <= 1'b0;
          cap_reg <= '0;
        end else if (sine_gen) begin
          got_reg <= 1'b0;
        end else if ((state_reg == ST_WAIT) && voice_ready[gi]) begin
          got_reg <= 1'b1;
          cap_reg <= voice_active[gi] ? voice_sample[gi*SAMPLE_W +: SAMPLE_W] : '0;
        end
      end

      assign got_flat[gi]                        = got_reg;
      assign cap_flat[gi*SAMPLE_W +: SAMPLE_W]   = cap_reg;
    end
  endgenerate

  assign all_done = &done_with_note;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // This cycle's readies count toward completion, saving a cycle in WAIT.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (generate_next_sample) state_next = ST_WAIT;
      ST_WAIT: if (&(got_flat | voice_ready)) state_next = ST_SUM;
      ST_SUM:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    sine_gen = (state_reg == ST_IDLE) && generate_next_sample;
  end

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      sum_c = sum_c + SUM_W'($signed(cap_flat[i*SAMPLE_W +: SAMPLE_W]));
    end
    shifted_c = sum_c >>> GAIN_SHIFT;
    if (shifted_c > SAT_MAX) begin
      sat_c = SAT_MAX[SAMPLE_W-1:0];
    end else if (shifted_c < SAT_MIN) begin
      sat_c = SAT_MIN[SAMPLE_W-1:0];
    end else begin
      sat_c = shifted_c[SAMPLE_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_out       <= '0;
      new_sample_ready <= 1'b0;
      overrun          <= 1'b0;
    end else begin
      new_sample_ready <= (state_reg == ST_SUM);
      if (state_reg == ST_SUM) begin
        sample_out <= sat_c;
      end
      if (generate_next_sample && (state_reg != ST_IDLE)) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_poly_note_player.sv
// tb_poly_note_player
//   Drives two player instances with shared stimulus: the default build
//   (4 voices, gain shift 2) and a 3-voice build with gain shift 0, which
//   saturates on large sums and has an unused voice_sel code. The per-voice
//   sine samples are overridden with programmable values; ready timing still
//   comes from the real sine readers. Expected mixer outputs are queued when
//   a request is issued and compared when new_sample_ready pulses.

module tb_poly_note_player;

  logic        clk = 1'b0;
  logic        reset;
  logic        play_enable;
  logic        load_new_note;
  logic [1:0]  voice_sel;
  logic [5:0]  note_to_load;
  logic [5:0]  duration_to_load;
  logic        beat;
  logic        generate_next_sample;

  logic [3:0]  done_a;
  logic        all_done_a;
  logic [15:0] sample_a;
  logic        nsr_a;
  logic        ovr_a;
  logic [2:0]  done_b;
  logic        all_done_b;
  logic [15:0] sample_b;
  logic        nsr_b;
  logic        ovr_b;

  logic [63:0] stub_a;
  logic [47:0] stub_b;

  int n_checks = 0;
  int n_fail   = 0;
  int txn      = 0;

  logic [15:0] q_a[$];
  logic [15:0] q_b[$];
  logic [15:0] mon_exp;

  typedef struct {
    logic [63:0] stubs;   // {v3, v2, v1, v0}
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } mix_vec_t;

  mix_vec_t vecs[7];

  always #5 clk = ~clk;

  poly_note_player dut_a (
    .clk                  (clk),
    .reset                (reset),
    .play_enable          (play_enable),
    .load_new_note        (load_new_note),
    .voice_sel            (voice_sel),
    .note_to_load         (note_to_load),
    .duration_to_load     (duration_to_load),
    .beat                 (beat),
    .generate_next_sample (generate_next_sample),
    .done_with_note       (done_a),
    .all_done             (all_done_a),
    .sample_out           (sample_a),
    .new_sample_ready     (nsr_a),
    .overrun              (ovr_a)
  );

  poly_note_player #(
    .NUM_VOICES (3),
    .GAIN_SHIFT (0)
  ) dut_b (
    .clk                  (clk),
    .reset                (reset),
    .play_enable          (play_enable),
    .load_new_note        (load_new_note),
    .voice_sel            (voice_sel),
    .note_to_load         (note_to_load),
    .duration_to_load     (duration_to_load),
    .beat                 (beat),
    .generate_next_sample (generate_next_sample),
    .done_with_note       (done_b),
    .all_done             (all_done_b),
    .sample_out           (sample_b),
    .new_sample_ready     (nsr_b),
    .overrun              (ovr_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_stubs(input logic [63:0] s);
    stub_a = s;
    stub_b = s[47:0];
    force dut_a.voice_sample = stub_a;
    force dut_b.voice_sample = stub_b;
  endtask

  // Scoreboard: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (nsr_a === 1'b1) begin
        if (q_a.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pulse_a: unexpected pulse with sample 0x%h, required no pulse", sample_a);
        end else begin
          mon_exp = q_a.pop_front();
          check("mix_a", 32'(sample_a), 32'(mon_exp));
          $display("txn %0d dut_a sample_out=0x%h expected=0x%h", txn, sample_a, mon_exp);
        end
      end
      if (nsr_b === 1'b1) begin
        if (q_b.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pulse_b: unexpected pulse with sample 0x%h, required no pulse", sample_b);
        end else begin
          mon_exp = q_b.pop_front();
          check("mix_b", 32'(sample_b), 32'(mon_exp));
          $display("txn %0d dut_b sample_out=0x%h expected=0x%h", txn, sample_b, mon_exp);
        end
      end
    end
  end

  task automatic load_voice(input logic [1:0] sel, input logic [5:0] note,
                            input logic [5:0] dur, input logic with_beat);
    @(posedge clk); #1;
    load_new_note    = 1'b1;
    voice_sel        = sel;
    note_to_load     = note;
    duration_to_load = dur;
    beat             = with_beat;
    @(posedge clk); #1;
    load_new_note    = 1'b0;
    beat             = 1'b0;
  endtask

  task automatic beat_pulse();
    @(posedge clk); #1;
    beat = 1'b1;
    @(posedge clk); #1;
    beat = 1'b0;
  endtask

  // mode 0: plain request; 1: pause right after the request;
  // 2: request held for a second cycle (lands in WAIT).
  task automatic do_request(input logic [15:0] ea, input logic [15:0] eb, input int mode);
    int lat;
    int exp_lat;
    lat     = 0;
    exp_lat = (mode == 2) ? 4 : 5;
    txn++;
    @(posedge clk); #1;
    q_a.push_back(ea);
    q_b.push_back(eb);
    generate_next_sample = 1'b1;
    if (mode == 2) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    generate_next_sample = 1'b0;
    if (mode == 1) play_enable = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (nsr_a === 1'b1) begin
        lat = k;
        break;
      end
    end
    check("latency", 32'(lat), 32'(exp_lat));
    if (lat == 0) begin
      q_a.delete();
      q_b.delete();
    end
    play_enable = 1'b1;
  endtask

  task automatic count_pulses(input int cycles, output int cnt);
    cnt = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (nsr_a === 1'b1 || nsr_b === 1'b1) cnt++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;

    vecs[0] = '{64'h7000_7000_7000_7000, 16'h7000, 16'h7FFF};
    vecs[1] = '{64'h8000_8000_8000_8000, 16'h8000, 16'h8000};
    vecs[2] = '{64'h0000_0000_2000_1000, 16'h0C00, 16'h3000};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 16'hFFFF, 16'hFFFD};
    vecs[4] = '{64'h0004_1234_C000_4000, 16'h048E, 16'h1234};
    vecs[5] = '{64'h0001_8000_7FFF_7FFF, 16'h1FFF, 16'h7FFE};
    vecs[6] = '{64'h0000_0000_0000_FFFB, 16'hFFFE, 16'hFFFB};

    reset                = 1'b0;
    play_enable          = 1'b0;
    load_new_note        = 1'b0;
    voice_sel            = 2'd0;
    note_to_load         = 6'd0;
    duration_to_load     = 6'd0;
    beat                 = 1'b0;
    generate_next_sample = 1'b0;
    set_stubs(64'h1234_1234_1234_1234);

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_done_a", 32'(done_a), 32'hF);
    check("rst_done_b", 32'(done_b), 32'h7);
    check("rst_all_done", 32'(all_done_a), 32'h1);
    check("rst_sample", 32'(sample_a), 32'h0);
    check("rst_nsr", 32'(nsr_a), 32'h0);
    check("rst_overrun", 32'(ovr_a), 32'h0);
    @(posedge clk); #1;
    reset       = 1'b1;
    play_enable = 1'b1;

    // No voice loaded: request yields silence after five cycles.
    do_request(16'h0000, 16'h0000, 0);
    check("idle_all_done", 32'(all_done_a), 32'h1);

    // Duration countdown on voice 2.
    load_voice(2'd2, 6'd10, 6'd3, 1'b0);
    @(negedge clk);
    check("dur_load", 32'(done_a[2]), 32'h0);
    check("dur_all_done", 32'(all_done_a), 32'h0);
    for (int b = 1; b <= 3; b++) begin
      beat_pulse();
      @(negedge clk);
      check("dur_beat_a", 32'(done_a[2]), (b == 3) ? 32'h1 : 32'h0);
      check("dur_beat_b", 32'(done_b[2]), (b == 3) ? 32'h1 : 32'h0);
    end
    beat_pulse();
    @(negedge clk);
    check("dur_no_wrap", 32'(done_a[2]), 32'h1);

    // Paused beats leave the remaining time untouched.
    load_voice(2'd2, 6'd10, 6'd3, 1'b0);
    play_enable = 1'b0;
    beat_pulse();
    beat_pulse();
    play_enable = 1'b1;
    beat_pulse();
    beat_pulse();
    @(negedge clk);
    check("pause_hold", 32'(done_a[2]), 32'h0);
    beat_pulse();
    @(negedge clk);
    check("pause_resume", 32'(done_a[2]), 32'h1);

    // Load together with a beat: loaded voice takes the new duration,
    // the other voice still counts down.
    load_voice(2'd2, 6'd10, 6'd2, 1'b0);
    load_voice(2'd1, 6'd4, 6'd2, 1'b1);
    @(negedge clk);
    check("ldbeat_v1", 32'(done_a[1]), 32'h0);
    check("ldbeat_v2", 32'(done_a[2]), 32'h0);
    beat_pulse();
    @(negedge clk);
    check("ldbeat_v1_b1", 32'(done_a[1]), 32'h0);
    check("ldbeat_v2_b1", 32'(done_a[2]), 32'h1);
    beat_pulse();
    @(negedge clk);
    check("ldbeat_v1_b2", 32'(done_b[1]), 32'h1);

    // voice_sel beyond the 3-voice build is ignored there.
    load_voice(2'd3, 6'd7, 6'd5, 1'b0);
    @(negedge clk);
    check("sel_oob_b", 32'(done_b), 32'h7);
    check("sel_v3_a", 32'(done_a), 32'h7);

    // All voices active; table of mixer cases.
    for (int v = 0; v < 4; v++) begin
      load_voice(2'(v), 6'(v + 1), 6'd63, 1'b0);
    end
    @(negedge clk);
    check("active_done_a", 32'(done_a), 32'h0);
    check("active_done_b", 32'(done_b), 32'h0);
    for (int i = 0; i < 7; i++) begin
      set_stubs(vecs[i].stubs);
      do_request(vecs[i].exp_a, vecs[i].exp_b, 0);
    end

    // Voice 0 resting, voices 2 and 3 done via zero-duration loads.
    load_voice(2'd0, 6'd0, 6'd10, 1'b0);
    load_voice(2'd2, 6'd5, 6'd0, 1'b0);
    load_voice(2'd3, 6'd5, 6'd0, 1'b0);
    @(negedge clk);
    check("mixdone_a", 32'(done_a), 32'hC);
    check("mixdone_b", 32'(done_b), 32'h4);
    set_stubs(64'h7777_5555_2000_1000);
    do_request(16'h0800, 16'h2000, 0);
    check("hold_sample", 32'(sample_a), 32'h0800);

    // Pause right after the request: captures come back silent.
    do_request(16'h0000, 16'h0000, 1);

    // Second request while waiting: flagged, still one pulse.
    @(negedge clk);
    check("ovr_before", 32'(ovr_a), 32'h0);
    do_request(16'h0800, 16'h2000, 2);
    count_pulses(10, cnt);
    check("ovr_extra_pulse", 32'(cnt), 32'h0);
    check("ovr_a", 32'(ovr_a), 32'h1);
    check("ovr_b", 32'(ovr_b), 32'h1);

    // Reset while waiting: request aborted, outputs back to reset values.
    txn++;
    @(posedge clk); #1;
    generate_next_sample = 1'b1;
    @(posedge clk); #1;
    generate_next_sample = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_sample", 32'(sample_a), 32'h0);
    check("midrst_overrun", 32'(ovr_a), 32'h0);
    check("midrst_done", 32'(done_a), 32'hF);
    check("midrst_nsr", 32'(nsr_a), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    count_pulses(10, cnt);
    check("midrst_no_pulse", 32'(cnt), 32'h0);

    load_voice(2'd1, 6'd3, 6'd20, 1'b0);
    set_stubs(64'h7FFF_7FFF_4000_7FFF);
    do_request(16'h1000, 16'h4000, 0);

    repeat (4) @(posedge clk);
    check("sb_empty", 32'(q_a.size() + q_b.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
